// File: rtl/qam_pkg.sv
// ---------------------------------------------------------------------------
// qam_pkg
//   Shared constants and types for the 4-point QAM modulation link.
//   Holds the 128-entry signed 9-bit carrier tables (amplitude 255, one
//   carrier cycle per symbol period), the symbol period, the 2-bit symbol
//   type with its four encodings, and the symbol decision helper.
//   No ports.
// ---------------------------------------------------------------------------
package qam_pkg;

  localparam int SYM_PERIOD = 128;
  localparam int PHASE_W    = 7;
  localparam int SAMPLE_W   = 9;
  localparam int PROD_W     = 2 * SAMPLE_W;

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(SYM_PERIOD - 1);

  // bit1 = I negative, bit0 = Q positive
  typedef enum logic [1:0] {
    SYM_IP_QN = 2'b00,
    SYM_IP_QP = 2'b01,
    SYM_IN_QN = 2'b10,
    SYM_IN_QP = 2'b11
  } sym_t;

  localparam logic signed [SAMPLE_W-1:0] SIN_TAB [0:SYM_PERIOD-1] = '{
     9'sd0,    9'sd13,   9'sd25,   9'sd37,   9'sd50,   9'sd62,   9'sd74,   9'sd86,
     9'sd98,   9'sd109,  9'sd120,  9'sd131,  9'sd142,  9'sd152,  9'sd162,  9'sd171,
     9'sd180,  9'sd189,  9'sd197,  9'sd205,  9'sd212,  9'sd219,  9'sd225,  9'sd231,
     9'sd236,  9'sd240,  9'sd244,  9'sd247,  9'sd250,  9'sd252,  9'sd254,  9'sd255,
     9'sd255,  9'sd255,  9'sd254,  9'sd252,  9'sd250,  9'sd247,  9'sd244,  9'sd240,
     9'sd236,  9'sd231,  9'sd225,  9'sd219,  9'sd212,  9'sd205,  9'sd197,  9'sd189,
     9'sd180,  9'sd171,  9'sd162,  9'sd152,  9'sd142,  9'sd131,  9'sd120,  9'sd109,
     9'sd98,   9'sd86,   9'sd74,   9'sd62,   9'sd50,   9'sd37,   9'sd25,   9'sd13,
     9'sd0,   -9'sd13,  -9'sd25,  -9'sd37,  -9'sd50,  -9'sd62,  -9'sd74,  -9'sd86,
    -9'sd98,  -9'sd109, -9'sd120, -9'sd131, -9'sd142, -9'sd152, -9'sd162, -9'sd171,
    -9'sd180, -9'sd189, -9'sd197, -9'sd205, -9'sd212, -9'sd219, -9'sd225, -9'sd231,
    -9'sd236, -9'sd240, -9'sd244, -9'sd247, -9'sd250, -9'sd252, -9'sd254, -9'sd255,
    -9'sd255, -9'sd255, -9'sd254, -9'sd252, -9'sd250, -9'sd247, -9'sd244, -9'sd240,
    -9'sd236, -9'sd231, -9'sd225, -9'sd219, -9'sd212, -9'sd205, -9'sd197, -9'sd189,
    -9'sd180, -9'sd171, -9'sd162, -9'sd152, -9'sd142, -9'sd131, -9'sd120, -9'sd109,
    -9'sd98,  -9'sd86,  -9'sd74,  -9'sd62,  -9'sd50,  -9'sd37,  -9'sd25,  -9'sd13
  };

  // Quarter-cycle shifted copy of SIN_TAB
  localparam logic signed [SAMPLE_W-1:0] COS_TAB [0:SYM_PERIOD-1] = '{
     9'sd255,  9'sd255,  9'sd254,  9'sd252,  9'sd250,  9'sd247,  9'sd244,  9'sd240,
     9'sd236,  9'sd231,  9'sd225,  9'sd219,  9'sd212,  9'sd205,  9'sd197,  9'sd189,
     9'sd180,  9'sd171,  9'sd162,  9'sd152,  9'sd142,  9'sd131,  9'sd120,  9'sd109,
     9'sd98,   9'sd86,   9'sd74,   9'sd62,   9'sd50,   9'sd37,   9'sd25,   9'sd13,
     9'sd0,   -9'sd13,  -9'sd25,  -9'sd37,  -9'sd50,  -9'sd62,  -9'sd74,  -9'sd86,
    -9'sd98,  -9'sd109, -9'sd120, -9'sd131, -9'sd142, -9'sd152, -9'sd162, -9'sd171,
    -9'sd180, -9'sd189, -9'sd197, -9'sd205, -9'sd212, -9'sd219, -9'sd225, -9'sd231,
    -9'sd236, -9'sd240, -9'sd244, -9'sd247, -9'sd250, -9'sd252, -9'sd254, -9'sd255,
    -9'sd255, -9'sd255, -9'sd254, -9'sd252, -9'sd250, -9'sd247, -9'sd244, -9'sd240,
    -9'sd236, -9'sd231, -9'sd225, -9'sd219, -9'sd212, -9'sd205, -9'sd197, -9'sd189,
    -9'sd180, -9'sd171, -9'sd162, -9'sd152, -9'sd142, -9'sd131, -9'sd120, -9'sd109,
    -9'sd98,  -9'sd86,  -9'sd74,  -9'sd62,  -9'sd50,  -9'sd37,  -9'sd25,  -9'sd13,
     9'sd0,    9'sd13,   9'sd25,   9'sd37,   9'sd50,   9'sd62,   9'sd74,   9'sd86,
     9'sd98,   9'sd109,  9'sd120,  9'sd131,  9'sd142,  9'sd152,  9'sd162,  9'sd171,
     9'sd180,  9'sd189,  9'sd197,  9'sd205,  9'sd212,  9'sd219,  9'sd225,  9'sd231,
     9'sd236,  9'sd240,  9'sd244,  9'sd247,  9'sd250,  9'sd252,  9'sd254,  9'sd255
  };

  // Map correlation signs onto the symbol; a zero correlation counts as
  // "not negative" for I and "not positive" for Q.
  function automatic sym_t symDecide(input logic iNeg, input logic qPos);
    return sym_t'({iNeg, qPos});
  endfunction

endpackage

// File: rtl/qam_corr.sv
// ---------------------------------------------------------------------------
// qam_corr
//   One correlation channel of the QAM demodulator: carrier table lookup,
//   single-cycle multiply-accumulate and combinational final sum.
//   USE_SIN selects the sine table (Q channel) instead of cosine (I channel).
//
//   Ports:
//     clk       in   sample clock, rising edge
//     reset     in   asynchronous active-low reset
//     phase_i   in   carrier phase of the sample on sample_i
//     accept_i  in   sample_i is accepted on this edge
//     sample_i  in   signed carrier sample
//     fin_o     out  accumulator plus current product (final sum at phase 127)
// ---------------------------------------------------------------------------
module qam_corr
  import qam_pkg::*;
#(
  parameter int ACC_W   = 25,
  parameter bit USE_SIN = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PHASE_W-1:0]         phase_i,
  input  logic                       accept_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  output logic signed [ACC_W-1:0]    fin_o
);

  logic signed [SAMPLE_W-1:0] coef;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prodExt;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;

  // Coefficient for the current phase from the selected carrier table
  always_comb begin
    coef = USE_SIN ? SIN_TAB[phase_i] : COS_TAB[phase_i];
  end

  assign prod    = sample_i * coef;
  assign prodExt = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign fin_o   = acc_q + prodExt;

  // Accumulate phases 1..126, skip the phase-0 symbol-load slot, and clear
  // on phase 127 since that sample is folded into fin_o by the top level.
  always_comb begin
    acc_d = acc_q;
    if (accept_i) begin
      if (phase_i == LAST_PHASE) begin
        acc_d = '0;
      end else if (phase_i != '0) begin
        acc_d = acc_q + prodExt;
      end
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/qam_demod.sv
// ---------------------------------------------------------------------------
// qam_demod
//   Coherent demodulator for the 4-point QAM carrier. Correlates each
//   128-sample symbol period against the cos (I) and sin (Q) carrier
//   tables and registers one 2-bit symbol per period.
//
//   Optional feature macro: QAM_DEMOD_ERR_EN enables the low-confidence
//   check on sym_err; without it sym_err is tied low.
//
//   Ports:
//     clk           in   sample clock, rising edge
//     reset         in   asynchronous active-low reset
//     sample_in     in   signed 9-bit carrier sample
//     sample_valid  in   sample_in is accepted on this edge
//     sym_out       out  recovered symbol, registered
//     sym_valid     out  one-cycle pulse when the outputs carry a new symbol
//     sym_err       out  low-confidence flag for the current symbol
//     i_corr        out  final cosine correlation of the last symbol
//     q_corr        out  final sine correlation of the last symbol
// ---------------------------------------------------------------------------
module qam_demod
  import qam_pkg::*;
#(
  parameter int ACC_W      = 25,
  parameter int ERR_THRESH = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic [1:0]                 sym_out,
  output logic                       sym_valid,
  output logic                       sym_err,
  output logic signed [ACC_W-1:0]    i_corr,
  output logic signed [ACC_W-1:0]    q_corr
);

  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic                    lastPhase;
  logic signed [ACC_W-1:0] iFin, qFin;

  sym_t                    sym_q, sym_d;
  logic                    symValid_q, symValid_d;
  logic signed [ACC_W-1:0] iCorr_q, iCorr_d;
  logic signed [ACC_W-1:0] qCorr_q, qCorr_d;

  assign lastPhase = sample_valid && (phase_q == LAST_PHASE);

  qam_corr #(.ACC_W(ACC_W), .USE_SIN(1'b0)) u_corrI (
    .clk      (clk),
    .reset    (reset),
    .phase_i  (phase_q),
    .accept_i (sample_valid),
    .sample_i (sample_in),
    .fin_o    (iFin)
  );

  qam_corr #(.ACC_W(ACC_W), .USE_SIN(1'b1)) u_corrQ (
    .clk      (clk),
    .reset    (reset),
    .phase_i  (phase_q),
    .accept_i (sample_valid),
    .sample_i (sample_in),
    .fin_o    (qFin)
  );

  // Phase counter wraps naturally at 128 and holds through valid gaps
  always_comb begin
    phase_d = phase_q;
    if (sample_valid) begin
      phase_d = phase_q + 7'd1;
    end
  end

  // Capture the decision and final correlations on the phase-127 accept;
  // the pulse is simply the registered phase-127 accept so it always drops
  // on the following edge.
  always_comb begin
    symValid_d = lastPhase;
    sym_d      = sym_q;
    iCorr_d    = iCorr_q;
    qCorr_d    = qCorr_q;
    if (lastPhase) begin
      sym_d   = symDecide(iFin[ACC_W-1], !qFin[ACC_W-1] && (qFin != '0));
      iCorr_d = iFin;
      qCorr_d = qFin;
    end
  end

  // Phase and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q    <= '0;
      sym_q      <= SYM_IP_QN;
      symValid_q <= 1'b0;
      iCorr_q    <= '0;
      qCorr_q    <= '0;
    end else begin
      phase_q    <= phase_d;
      sym_q      <= sym_d;
      symValid_q <= symValid_d;
      iCorr_q    <= iCorr_d;
      qCorr_q    <= qCorr_d;
    end
  end

  assign sym_out   = sym_q;
  assign sym_valid = symValid_q;
  assign i_corr    = iCorr_q;
  assign q_corr    = qCorr_q;

`ifdef QAM_DEMOD_ERR_EN
  // One extra bit so negating the most negative correlation cannot overflow
  localparam logic [ACC_W:0] THRESH = (ACC_W+1)'(ERR_THRESH);

  logic signed [ACC_W:0] iWide, qWide;
  logic [ACC_W:0]        iMag, qMag;
  logic                  err_q, err_d;

  assign iWide = {iFin[ACC_W-1], iFin};
  assign qWide = {qFin[ACC_W-1], qFin};
  assign iMag  = iWide[ACC_W] ? -iWide : iWide;
  assign qMag  = qWide[ACC_W] ? -qWide : qWide;

  // Flag the symbol when either axis is too weak to trust its sign
  always_comb begin
    err_d = err_q;
    if (lastPhase) begin
      err_d = (iMag < THRESH) || (qMag < THRESH);
    end
  end

  // Error flag register, updated alongside sym_out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign sym_err = err_q;
`else
  assign sym_err = 1'b0;
`endif

endmodule

// File: tb/tb_qam_demod.sv
// ---------------------------------------------------------------------------
// tb_qam_demod
//   Self-checking bench for qam_demod. Builds modulated symbols from the
//   shared carrier tables, computes the expected correlations and decision
//   itself, and queues them with the expected pulse cycle; a monitor pops and
//   compares on every sym_valid pulse. Honours QAM_DEMOD_ERR_EN for sym_err.
// ---------------------------------------------------------------------------
module tb_qam_demod;
  import qam_pkg::*;

  localparam int     ACC_W      = 25;
  localparam longint ERR_THRESH = 100000;

  logic                    clk = 1'b0;
  logic                    reset;
  logic signed [8:0]       sample_in;
  logic                    sample_valid;
  logic [1:0]              sym_out;
  logic                    sym_valid;
  logic                    sym_err;
  logic signed [ACC_W-1:0] i_corr;
  logic signed [ACC_W-1:0] q_corr;

  typedef struct {
    logic [1:0] sym;
    longint     iVal;
    longint     qVal;
    logic       err;
    int         expCyc;
  } exp_t;

  exp_t              sb[$];
  logic signed [8:0] symBuf [0:127];
  int                cyc = 0;
  int                testsRun = 0;
  int                testsFailed = 0;

  qam_demod #(.ACC_W(ACC_W), .ERR_THRESH(100000)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sym_out      (sym_out),
    .sym_valid    (sym_valid),
    .sym_err      (sym_err),
    .i_corr       (i_corr),
    .q_corr       (q_corr)
  );

  always #5 clk = ~clk;

  // Edge counter used to predict exactly when each pulse must appear
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic signed [8:0] s, input logic v);
    @(negedge clk);
    sample_in    = s;
    sample_valid = v;
  endtask

  // Modulated symbol: amp * (cI*cos + cQ*sin) with tables normalised by 256
  task automatic buildSymbol(input int cI, input int cQ, input int amp);
    for (int p = 0; p < 128; p++) begin
      symBuf[p] = 9'((amp * (cI * int'(COS_TAB[p]) + cQ * int'(SIN_TAB[p]))) / 256);
    end
  endtask

  // Drive nSamples of symBuf; the expectation is queued when phase 127 is driven
  task automatic sendSymbol(input bit gappy, input int nSamples);
    exp_t   e;
    longint ei = 0;
    longint eq = 0;
    for (int p = 1; p < 128; p++) begin
      ei += longint'(symBuf[p]) * longint'(COS_TAB[p]);
      eq += longint'(symBuf[p]) * longint'(SIN_TAB[p]);
    end
    e.sym  = {ei < 0, eq > 0};
    e.iVal = ei;
    e.qVal = eq;
`ifdef QAM_DEMOD_ERR_EN
    e.err  = ((ei < 0 ? -ei : ei) < ERR_THRESH) || ((eq < 0 ? -eq : eq) < ERR_THRESH);
`else
    e.err  = 1'b0;
`endif
    for (int p = 0; p < nSamples; p++) begin
      if (gappy) applyStimulus(9'sd0, 1'b0);
      applyStimulus(symBuf[p], 1'b1);
      if (p == 127) begin
        e.expCyc = cyc + 1;
        sb.push_back(e);
      end
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b1 && sym_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", sym_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        checkOutput("sym_out", sym_out, e.sym);
        checkOutput("i_corr", i_corr, e.iVal);
        checkOutput("q_corr", q_corr, e.qVal);
        checkOutput("sym_err", sym_err, e.err);
        checkOutput("pulse_cycle", cyc, e.expCyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time %0t, required finish before 1000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_sym_out", sym_out, 2'b00);
    checkOutput("reset_sym_valid", sym_valid, 1'b0);
    checkOutput("reset_sym_err", sym_err, 1'b0);
    checkOutput("reset_i_corr", i_corr, 0);
    checkOutput("reset_q_corr", q_corr, 0);
    @(negedge clk);
    reset = 1'b1;

    // Symbol 00 then 01, 11, 10 back to back
    buildSymbol(1, -1, 100);
    sendSymbol(1'b0, 128);
    buildSymbol(1, 1, 100);
    sendSymbol(1'b0, 128);
    buildSymbol(-1, 1, 100);
    sendSymbol(1'b0, 128);
    buildSymbol(-1, -1, 100);
    sendSymbol(1'b0, 128);

    // Outputs hold between pulses
    repeat (4) applyStimulus(9'sd0, 1'b0);
    checkOutput("hold_sym_out", sym_out, 2'b10);
    checkOutput("hold_sym_valid", sym_valid, 1'b0);

    // Symbol 00 with sample_valid toggling every other cycle
    buildSymbol(1, -1, 100);
    sendSymbol(1'b1, 128);
    repeat (3) applyStimulus(9'sd0, 1'b0);

    // All-zero samples
    buildSymbol(0, 0, 0);
    sendSymbol(1'b0, 128);

    // Phase-0 sample must not affect the correlations
    buildSymbol(1, 1, 100);
    symBuf[0] = 9'sd0;
    sendSymbol(1'b0, 128);
    symBuf[0] = 9'sd255;
    sendSymbol(1'b0, 128);
    repeat (3) applyStimulus(9'sd0, 1'b0);

    // Reset at phase 60 mid-symbol, then a clean symbol 11
    buildSymbol(-1, -1, 100);
    sendSymbol(1'b0, 60);
    @(negedge clk);
    sample_valid = 1'b0;
    reset        = 1'b0;
    #1;
    checkOutput("midreset_sym_out", sym_out, 2'b00);
    checkOutput("midreset_sym_valid", sym_valid, 1'b0);
    checkOutput("midreset_sym_err", sym_err, 1'b0);
    checkOutput("midreset_i_corr", i_corr, 0);
    checkOutput("midreset_q_corr", q_corr, 0);
    @(negedge clk);
    reset = 1'b1;
    buildSymbol(-1, 1, 100);
    sendSymbol(1'b0, 128);

    repeat (6) applyStimulus(9'sd0, 1'b0);
    checkOutput("pending_pulses", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
